// File: rtl/ascii_fmt_packer_pkg.sv
// Shared types and helpers for the ASCII token formatter.
package ascii_fmt_pkg;

    typedef enum logic [1:0] {
        TOK_NUM     = 2'd0,
        TOK_SPACE   = 2'd1,
        TOK_NEWLINE = 2'd2,
        TOK_RAW     = 2'd3
    } tok_type_t;

    // Mode 3 is an alias of signed decimal.
    typedef enum logic [1:0] {
        MODE_SDEC     = 2'd0,
        MODE_UDEC     = 2'd1,
        MODE_HEX      = 2'd2,
        MODE_SDEC_ALT = 2'd3
    } mode_t;

    localparam logic [7:0] CHAR_SPACE   = 8'h20;
    localparam logic [7:0] CHAR_NEWLINE = 8'h0A;
    localparam logic [7:0] CHAR_MINUS   = 8'h2D;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CONV   = 3'd1,
        S_PAD    = 3'd2,
        S_SIGN   = 3'd3,
        S_DIGITS = 3'd4,
        S_CHAR   = 3'd5
    } state_t;

    // Decimal digit count of 2^data_w - 1; hex never needs more digits than this.
    function automatic int max_digits(input int data_w);
        logic [63:0] v;
        int          n;
        v = (64'd1 << data_w) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 64'd0) begin
                n++;
                v = v / 64'd10;
            end
        end
        return n;
    endfunction

    // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'd0, d}) : (8'h37 + {4'd0, d});
    endfunction

endpackage

// File: rtl/ascii_fmt_packer_if.sv
// Token-in / char-out handshake bundle for the ASCII formatter.
interface ascii_fmt_packer_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_type;
    logic [1:0]        in_mode;
    logic [4:0]        in_width;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        ascii_data;
    logic              ascii_valid;
    logic              ascii_ready;

    // Producer of tokens and consumer of characters.
    modport master (
        output in_data, in_type, in_mode, in_width, in_valid, ascii_ready,
        input  in_ready, ascii_data, ascii_valid
    );

    // The formatter itself.
    modport slave (
        input  in_data, in_type, in_mode, in_width, in_valid, ascii_ready,
        output in_ready, ascii_data, ascii_valid
    );
endinterface

// File: rtl/ascii_fmt_packer_tok_fifo.sv
// Small synchronous show-ahead FIFO holding packed tokens.
module tok_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;
    logic                    do_push;
    logic                    do_pop;

    // A full FIFO refuses a push even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ascii_fmt_packer.sv
// Token stream to ASCII byte stream: numbers are converted LSB first into a
// digit buffer, then emitted as padding, sign and digits MSB first.
module ascii_fmt_packer
    import ascii_fmt_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    ascii_fmt_packer_if.slave  bus,
    output logic               busy,
    output logic [CNT_W-1:0]   chars_sent
);
    localparam int MAX_DIGITS = max_digits(DATA_W);
    localparam int IDX_W      = $clog2(MAX_DIGITS + 1);
    localparam int TOK_W      = DATA_W + 9;
    localparam logic [DATA_W-1:0] TEN = DATA_W'(10);

    // Token FIFO
    logic [TOK_W-1:0] tok_in;
    logic [TOK_W-1:0] tok_out;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // FSM state
    state_t                      state;
    logic [DATA_W-1:0]           mag;
    logic                        neg;
    logic                        hex;
    logic [4:0]                  width_r;
    logic [MAX_DIGITS-1:0][3:0]  dbuf;
    logic [IDX_W-1:0]            ndig;
    logic [IDX_W-1:0]            idx;
    logic [4:0]                  pad_cnt;
    logic                        valid_r;
    logic [7:0]                  data_r;

    // Unpacked head token
    logic [DATA_W-1:0] t_data;
    tok_type_t         t_type;
    mode_t             t_mode;
    logic [4:0]        t_width;
    logic              t_neg;

    // Conversion datapath
    logic [3:0]        dig;
    logic [DATA_W-1:0] mag_next;
    logic [IDX_W-1:0]  ndig_next;
    logic [5:0]        field_len;
    logic [5:0]        width6;
    logic [4:0]        pad_first;
    logic              hs;

    assign tok_in = {bus.in_data, bus.in_type, bus.in_mode, bus.in_width};
    assign push   = bus.in_valid && !full;
    assign pop    = (state == S_IDLE) && !empty;

    tok_fifo #(
        .W     (TOK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (tok_in),
        .rdata (tok_out),
        .full  (full),
        .empty (empty)
    );

    assign t_data  = tok_out[TOK_W-1 -: DATA_W];
    assign t_type  = tok_type_t'(tok_out[8:7]);
    assign t_mode  = mode_t'(tok_out[6:5]);
    assign t_width = tok_out[4:0];
    assign t_neg   = (t_mode != MODE_UDEC) && (t_mode != MODE_HEX) && t_data[DATA_W-1];

    assign dig       = hex ? mag[3:0] : 4'(mag % TEN);
    assign mag_next  = hex ? (mag >> 4) : (mag / TEN);
    assign ndig_next = ndig + IDX_W'(1);

    // Padding is computed while the final digit is produced, so it uses ndig_next.
    assign field_len = 6'(ndig_next) + {5'd0, neg};
    assign width6    = {1'b0, width_r};
    assign pad_first = (width6 > field_len) ? 5'(width6 - field_len) : 5'd0;

    assign hs = valid_r && bus.ascii_ready;

    assign bus.in_ready    = !full;
    assign bus.ascii_valid = valid_r;
    assign bus.ascii_data  = data_r;
    assign busy            = !empty || (state != S_IDLE);

    // Main FSM: pop, convert, then emit one char per handshake with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            mag     <= '0;
            neg     <= 1'b0;
            hex     <= 1'b0;
            width_r <= '0;
            dbuf    <= '0;
            ndig    <= '0;
            idx     <= '0;
            pad_cnt <= '0;
            valid_r <= 1'b0;
            data_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        case (t_type)
                            TOK_NUM: begin
                                neg     <= t_neg;
                                mag     <= t_neg ? -t_data : t_data;
                                hex     <= (t_mode == MODE_HEX);
                                width_r <= t_width;
                                ndig    <= '0;
                                state   <= S_CONV;
                            end
                            TOK_SPACE: begin
                                valid_r <= 1'b1;
                                data_r  <= CHAR_SPACE;
                                state   <= S_CHAR;
                            end
                            TOK_NEWLINE: begin
                                valid_r <= 1'b1;
                                data_r  <= CHAR_NEWLINE;
                                state   <= S_CHAR;
                            end
                            default: begin
                                valid_r <= 1'b1;
                                data_r  <= t_data[7:0];
                                state   <= S_CHAR;
                            end
                        endcase
                    end
                end

                S_CONV: begin
                    dbuf[ndig] <= dig;
                    ndig       <= ndig_next;
                    mag        <= mag_next;
                    if (mag_next == '0) begin
                        // idx points at the most significant digit just written.
                        idx     <= ndig;
                        valid_r <= 1'b1;
                        if (pad_first != 5'd0) begin
                            pad_cnt <= pad_first;
                            data_r  <= CHAR_SPACE;
                            state   <= S_PAD;
                        end else if (neg) begin
                            data_r <= CHAR_MINUS;
                            state  <= S_SIGN;
                        end else begin
                            data_r <= digit_char(dig);
                            state  <= S_DIGITS;
                        end
                    end
                end

                S_PAD: begin
                    if (hs) begin
                        if (pad_cnt == 5'd1) begin
                            if (neg) begin
                                data_r <= CHAR_MINUS;
                                state  <= S_SIGN;
                            end else begin
                                data_r <= digit_char(dbuf[idx]);
                                state  <= S_DIGITS;
                            end
                        end else begin
                            pad_cnt <= pad_cnt - 5'd1;
                        end
                    end
                end

                S_SIGN: begin
                    if (hs) begin
                        data_r <= digit_char(dbuf[idx]);
                        state  <= S_DIGITS;
                    end
                end

                S_DIGITS: begin
                    if (hs) begin
                        if (idx == '0) begin
                            valid_r <= 1'b0;
                            data_r  <= '0;
                            state   <= S_IDLE;
                        end else begin
                            idx    <= idx - IDX_W'(1);
                            data_r <= digit_char(dbuf[idx - IDX_W'(1)]);
                        end
                    end
                end

                S_CHAR: begin
                    if (hs) begin
                        valid_r <= 1'b0;
                        data_r  <= '0;
                        state   <= S_IDLE;
                    end
                end

                default: begin
                    valid_r <= 1'b0;
                    data_r  <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // Output handshake counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) chars_sent <= '0;
        else if (hs) chars_sent <= chars_sent + 1'b1;
    end

endmodule

// File: tb/tb_ascii_fmt_packer.sv
// Directed bench for ascii_fmt_packer with hand-computed expected strings.
module tb_ascii_fmt_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [31:0] chars_sent;

    ascii_fmt_packer_if #(.DATA_W(32)) bus ();

    ascii_fmt_packer #(
        .DATA_W     (32),
        .FIFO_DEPTH (4),
        .CNT_W      (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .chars_sent (chars_sent)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input string obs, input string exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s observed=\"%s\" expected=\"%s\"", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push(input logic [31:0] d, input logic [1:0] t, input logic [1:0] m,
                        input logic [4:0] w);
        int g = 0;
        bus.in_data  = d;
        bus.in_type  = t;
        bus.in_mode  = m;
        bus.in_width = w;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("push_timeout", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Collect n chars; with rnd, ascii_ready toggles randomly and stalls are checked for stability.
    task automatic collect(input int n, input bit rnd, output string s);
        int         got  = 0;
        int         cyc  = 0;
        bit         held = 1'b0;
        logic [7:0] hd   = 8'h00;
        s = "";
        while (got < n && cyc < 2000) begin
            if (held) begin
                chk("stall_valid", 64'(bus.ascii_valid), 64'd1);
                chk("stall_data", 64'(bus.ascii_data), 64'(hd));
            end
            bus.ascii_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            held = 1'b0;
            if (bus.ascii_valid && bus.ascii_ready) begin
                s = $sformatf("%s%c", s, bus.ascii_data);
                got++;
            end else if (bus.ascii_valid) begin
                held = 1'b1;
                hd   = bus.ascii_data;
            end
            @(negedge clk);
            cyc++;
        end
        bus.ascii_ready = 1'b0;
        chk("collect_count", 64'(got), 64'(n));
    endtask

    task automatic expect_str(input string tag, input string exp, input bit rnd);
        string s;
        collect(exp.len(), rnd, s);
        chk_s(tag, s, exp);
        exp_cnt += exp.len();
        chk({tag, "_cnt"}, 64'(chars_sent), 64'(exp_cnt));
    endtask

    initial begin
        int lat;
        rst_n           = 1'b0;
        bus.in_data     = '0;
        bus.in_type     = '0;
        bus.in_mode     = '0;
        bus.in_width    = '0;
        bus.in_valid    = 1'b0;
        bus.ascii_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_valid", 64'(bus.ascii_valid), 64'd0);
        chk("rst_data", 64'(bus.ascii_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_cnt", 64'(chars_sent), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // -1234 signed, latency pop->first char = 1 + 4 digits
        bus.ascii_ready = 1'b1;
        push(32'hFFFF_FB2E, 2'd0, 2'd0, 5'd0);
        lat = 0;
        while (!bus.ascii_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("lat_neg1234", 64'(lat), 64'd5);
        expect_str("neg1234", "-1234", 1'b0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_valid", 64'(bus.ascii_valid), 64'd0);

        // Most negative value, signed then unsigned
        push(32'h8000_0000, 2'd0, 2'd0, 5'd0);
        expect_str("min_sdec", "-2147483648", 1'b0);
        push(32'h8000_0000, 2'd0, 2'd1, 5'd0);
        expect_str("min_udec", "2147483648", 1'b0);
        push(32'hFFFF_FFFF, 2'd0, 2'd1, 5'd0);
        expect_str("max_udec", "4294967295", 1'b0);

        // Hex with padding, zero, no truncation, letters
        push(32'h0000_00FF, 2'd0, 2'd2, 5'd6);
        expect_str("hex_ff_w6", "    FF", 1'b0);
        push(32'h0, 2'd0, 2'd2, 5'd0);
        expect_str("hex_zero", "0", 1'b0);
        push(32'h0000_01A3, 2'd0, 2'd2, 5'd2);
        expect_str("hex_1a3_w2", "1A3", 1'b0);
        push(32'hDEAD_BEEF, 2'd0, 2'd2, 5'd0);
        expect_str("hex_deadbeef", "DEADBEEF", 1'b0);

        // Mode 3 acts as signed; pad precedes the sign
        push(32'hFFFF_FFFB, 2'd0, 2'd3, 5'd4);
        expect_str("mode3_neg5_w4", "  -5", 1'b0);

        // Back-to-back tokens against a stalled sink fill the FIFO
        bus.ascii_ready = 1'b0;
        push(32'd5,  2'd0, 2'd0, 5'd0);
        push(32'd0,  2'd1, 2'd0, 5'd0);
        push(32'd42, 2'd0, 2'd0, 5'd0);
        push(32'd0,  2'd2, 2'd0, 5'd0);
        push(32'h21, 2'd3, 2'd0, 5'd0);
        chk("fifo_full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("fifo_full_busy", 64'(busy), 64'd1);
        expect_str("stream_rand", "5 42\n!", 1'b1);

        // Reset in the middle of a number
        push(32'd12345, 2'd0, 2'd0, 5'd0);
        expect_str("pre_reset", "12", 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_valid", 64'(bus.ascii_valid), 64'd0);
        chk("mid_rst_data", 64'(bus.ascii_data), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_cnt", 64'(chars_sent), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        exp_cnt = 0;
        push(32'd7, 2'd0, 2'd0, 5'd0);
        expect_str("after_rst_7", "7", 1'b0);

        // 'B' is pushed in the same cycle 'A' pops; fullness then lands on the 4th queued token
        bus.ascii_ready = 1'b0;
        push(32'h41, 2'd3, 2'd0, 5'd0);
        push(32'h42, 2'd3, 2'd0, 5'd0);
        push(32'h43, 2'd3, 2'd0, 5'd0);
        push(32'h44, 2'd3, 2'd0, 5'd0);
        chk("pushpop_not_full", 64'(bus.in_ready), 64'd1);
        push(32'h45, 2'd3, 2'd0, 5'd0);
        chk("pushpop_full", 64'(bus.in_ready), 64'd0);
        expect_str("raw_abcde", "ABCDE", 1'b1);

        repeat (3) @(negedge clk);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_valid", 64'(bus.ascii_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
